// File: rtl/tetris_grid_engine_if.sv
// Command, piece-feed and display-read signals shared by the playfield engine and its neighbours.
interface tetris_grid_engine_if #(
  parameter int GRID_W = 10,
  parameter int ROW_AW = 5
);
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic              cmd_ready;
  logic              piece_req;
  logic              piece_valid;
  logic [15:0]       piece_shape;
  logic [ROW_AW-1:0] rd_row;
  logic [GRID_W-1:0] rd_data;
  logic              locked;
  logic [15:0]       lines_cleared;
  logic              game_over;

  modport master (
    output cmd_valid, cmd, piece_valid, piece_shape, rd_row,
    input  cmd_ready, piece_req, rd_data, locked, lines_cleared, game_over
  );

  modport slave (
    input  cmd_valid, cmd, piece_valid, piece_shape, rd_row,
    output cmd_ready, piece_req, rd_data, locked, lines_cleared, game_over
  );
endinterface

// File: rtl/tetris_grid_engine.sv
// Tetris playfield: occupancy grid, one active 4x4 piece, collision, lock, line clear, game over.
// Optional hard drop (cmd 5) is built only when GRID_HARD_DROP_EN is defined.
module tetris_grid_engine #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 20,
  parameter int ROW_AW = 5
) (
  input  logic clock,
  input  logic reset,
  tetris_grid_engine_if.slave bus
);
  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int RW = $clog2(GRID_H);
  localparam logic signed [7:0] W8 = 8'(GRID_W);
  localparam logic signed [7:0] H8 = 8'(GRID_H);
  localparam logic signed [7:0] SPAWN_X = 8'((GRID_W - 4) / 2);
  localparam logic [RW-1:0] LAST_ROW = RW'(GRID_H - 1);
  localparam logic [GRID_W-1:0] COL0 = GRID_W'(1);

  typedef enum logic [3:0] {
    S_CLR, S_SPAWN, S_SCHK, S_IDLE, S_CHECK, S_LOCK, S_SCAN, S_SHIFT, S_OVER
  } state_t;

  state_t state_reg, state_next;
  logic [GRID_W-1:0] grid [GRID_H];
  logic [15:0] shape_reg, cand_shape_reg, rot_shape, cand_hit;
  logic signed [7:0] pos_x_reg, pos_y_reg, cand_x_reg, cand_y_reg;
  logic [2:0] op_reg;
  logic [RW-1:0] work_reg, scan_reg;
  logic [15:0] lines_reg;
  logic [GRID_W-1:0] rd_data_reg;
  logic [GRID_W-1:0] cell_cols [16];
  logic signed [7:0] cell_row [16];
  logic [GRID_W-1:0] piece_rows [GRID_H];
  logic coll, row_full, is_move, hard_op, drop_op, overlay_on, rd_in;
  logic signed [7:0] rd_y;

`ifdef GRID_HARD_DROP_EN
  assign hard_op = (op_reg == 3'd5);
  assign is_move = (bus.cmd >= 3'd1) && (bus.cmd <= 3'd5);
`else
  assign hard_op = 1'b0;
  assign is_move = (bus.cmd >= 3'd1) && (bus.cmd <= 3'd4);
`endif
  assign drop_op = (op_reg == 3'd3) || hard_op;

  // Per mask cell: candidate collision, rotation source and the committed piece's column/row.
  for (genvar gi = 0; gi < 16; gi++) begin : g_cell
    localparam int R = gi / 4;
    localparam int C = gi % 4;
    logic signed [7:0] cx, cy, px;
    assign rot_shape[gi] = shape_reg[4 * (3 - C) + R];
    assign cx = cand_x_reg + 8'(C);
    assign cy = cand_y_reg + 8'(R);
    assign cand_hit[gi] = cand_shape_reg[gi] &&
        (cx[7] || cx >= W8 || cy[7] || cy >= H8 || grid[cy[RW-1:0]][cx[CW-1:0]]);
    assign px = pos_x_reg + 8'(C);
    assign cell_row[gi] = pos_y_reg + 8'(R);
    assign cell_cols[gi] = (shape_reg[gi] && !px[7] && px < W8) ? (COL0 << px[CW-1:0]) : '0;
  end

  assign coll = |cand_hit;
  assign row_full = &grid[scan_reg];

  always_comb begin
    for (int k = 0; k < GRID_H; k++) begin
      piece_rows[k] = '0;
      for (int i = 0; i < 16; i++)
        if (cell_row[i] == 8'(k)) piece_rows[k] = piece_rows[k] | cell_cols[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_reg <= S_CLR;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CLR:   if (work_reg == LAST_ROW) state_next = S_SPAWN;
      S_SPAWN: if (bus.piece_valid) state_next = S_SCHK;
      S_SCHK:  state_next = coll ? S_OVER : S_IDLE;
      S_IDLE:  if (bus.cmd_valid && is_move) state_next = S_CHECK;
      S_CHECK: begin
        if (!coll) begin
          if (!hard_op) state_next = S_IDLE;
        end else begin
          state_next = drop_op ? S_LOCK : S_IDLE;
        end
      end
      S_LOCK:  state_next = S_SCAN;
      S_SCAN: begin
        if (row_full)             state_next = S_SHIFT;
        else if (scan_reg == '0)  state_next = S_SPAWN;
      end
      S_SHIFT: if (work_reg <= RW'(1)) state_next = S_SCAN;
      S_OVER:  state_next = S_OVER;
      default: state_next = S_CLR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shape_reg <= '0; cand_shape_reg <= '0;
      pos_x_reg <= '0; pos_y_reg <= '0; cand_x_reg <= '0; cand_y_reg <= '0;
      op_reg <= '0; work_reg <= '0; scan_reg <= '0; lines_reg <= '0;
    end else begin
      case (state_reg)
        S_CLR: work_reg <= work_reg + RW'(1);
        S_SPAWN: if (bus.piece_valid) begin
          shape_reg <= bus.piece_shape; cand_shape_reg <= bus.piece_shape;
          pos_x_reg <= SPAWN_X; cand_x_reg <= SPAWN_X;
          pos_y_reg <= '0; cand_y_reg <= '0;
        end
        S_IDLE: if (bus.cmd_valid && is_move) begin
          op_reg <= bus.cmd;
          cand_shape_reg <= shape_reg; cand_x_reg <= pos_x_reg; cand_y_reg <= pos_y_reg;
          case (bus.cmd)
            3'd1: cand_x_reg <= pos_x_reg - 8'sd1;
            3'd2: cand_x_reg <= pos_x_reg + 8'sd1;
            3'd3: cand_y_reg <= pos_y_reg + 8'sd1;
            3'd4: cand_shape_reg <= rot_shape;
`ifdef GRID_HARD_DROP_EN
            3'd5: cand_y_reg <= pos_y_reg + 8'sd1;
`endif
            default: ;
          endcase
        end
        S_CHECK: if (!coll) begin
          shape_reg <= cand_shape_reg; pos_x_reg <= cand_x_reg; pos_y_reg <= cand_y_reg;
          if (hard_op) cand_y_reg <= cand_y_reg + 8'sd1;
        end
        S_LOCK: scan_reg <= LAST_ROW;
        S_SCAN: begin
          if (row_full) begin
            if (lines_reg != '1) lines_reg <= lines_reg + 16'd1;
            work_reg <= scan_reg;
          end else if (scan_reg != '0) begin
            scan_reg <= scan_reg - RW'(1);
          end
        end
        S_SHIFT: if (work_reg != '0) work_reg <= work_reg - RW'(1);
        default: ;
      endcase
    end
  end

  // Grid contents are rebuilt by the CLR sweep after reset, so they carry no reset term.
  always_ff @(posedge clock) begin
    if (reset) begin
      case (state_reg)
        S_CLR: grid[work_reg] <= '0;
        S_LOCK: for (int k = 0; k < GRID_H; k++) grid[k] <= grid[k] | piece_rows[k];
        S_SHIFT: begin
          if (work_reg != '0) grid[work_reg] <= grid[work_reg - RW'(1)];
          if (work_reg <= RW'(1)) grid[0] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign overlay_on = (state_reg == S_IDLE) || (state_reg == S_CHECK);
  assign rd_y = 8'(bus.rd_row);
  assign rd_in = rd_y < H8;

  always_ff @(posedge clock) begin
    if (!reset)     rd_data_reg <= '0;
    else if (rd_in) rd_data_reg <= grid[bus.rd_row[RW-1:0]] |
                                   (overlay_on ? piece_rows[bus.rd_row[RW-1:0]] : '0);
    else            rd_data_reg <= '0;
  end

  assign bus.cmd_ready     = (state_reg == S_IDLE);
  assign bus.piece_req     = (state_reg == S_SPAWN);
  assign bus.locked        = (state_reg == S_LOCK);
  assign bus.game_over     = (state_reg == S_OVER);
  assign bus.lines_cleared = lines_reg;
  assign bus.rd_data       = rd_data_reg;
endmodule
